// File: rtl/alu_bcd_seq.sv
// alu_bcd_seq: handshaked multi-cycle ALU with a registered result and sequential double-dabble BCD conversion
module alu_bcd_seq #(
  parameter int WIDTH = 8,
  parameter int DIGITS = 5
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [WIDTH-1:0]      A,
  input  logic [WIDTH-1:0]      B,
  input  logic                  CarryIN,
  input  logic [2:0]            opCodeA,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [2*WIDTH-1:0]    result,
  output logic [4*DIGITS-1:0]   bcd,
  output logic                  negative,
  output logic                  CarryOUT,
  output logic                  overflow
);
  localparam int RW = 2*WIDTH;
  localparam int BW = 4*DIGITS;
  localparam int CW = $clog2(RW+1);
  typedef enum logic [1:0] {IDLE, EXEC, CONV, DONE} state_t;
  state_t state_q, state_d;
  logic [WIDTH-1:0] a_q, b_q;
  logic cin_q;
  logic [2:0] op_q;
  logic [RW-1:0] result_q, res_d, mul, bin_q;
  logic [BW-1:0] bcd_q, sh_q, adj;
  logic [BW+RW-1:0] shl;
  logic [CW-1:0] cnt_q;
  logic neg_q, co_q, ov_q, neg_d, co_d, ov_d, last;
  logic [WIDTH:0] sum, diff, mag;
  assign sum  = {1'b0, a_q} + {1'b0, b_q} + {{WIDTH{1'b0}}, cin_q};
  assign diff = {1'b0, a_q} - {1'b0, b_q} - {{WIDTH{1'b0}}, cin_q};
  assign mag  = {1'b0, b_q} + {{WIDTH{1'b0}}, cin_q} - {1'b0, a_q};
  assign mul  = {{WIDTH{1'b0}}, a_q} * {{WIDTH{1'b0}}, b_q};
  assign last = cnt_q == CW'(RW-1);
  always_comb begin
    res_d = op_q == 3'd0 ? {{(WIDTH-1){1'b0}}, sum} :
            op_q == 3'd1 ? (diff[WIDTH] ? {{(WIDTH-1){1'b0}}, mag} : {{WIDTH{1'b0}}, diff[WIDTH-1:0]}) :
            op_q == 3'd2 ? mul :
            op_q == 3'd3 ? {{WIDTH{1'b0}}, a_q & b_q} :
            op_q == 3'd4 ? {{WIDTH{1'b0}}, a_q | b_q} :
            op_q == 3'd5 ? {{WIDTH{1'b0}}, a_q ^ b_q} :
            op_q == 3'd6 ? {{WIDTH{1'b0}}, ~a_q} : {{WIDTH{1'b0}}, a_q};
    neg_d = op_q == 3'd1 && diff[WIDTH];
    co_d  = op_q == 3'd0 ? sum[WIDTH] : op_q == 3'd1 ? diff[WIDTH] : 1'b0;
    ov_d  = op_q == 3'd0 ? (a_q[WIDTH-1] == b_q[WIDTH-1] && sum[WIDTH-1] != a_q[WIDTH-1]) :
            op_q == 3'd1 ? (a_q[WIDTH-1] != b_q[WIDTH-1] && diff[WIDTH-1] != a_q[WIDTH-1]) : 1'b0;
    state_d = state_q == IDLE ? (in_valid ? EXEC : IDLE) :
              state_q == EXEC ? CONV :
              state_q == CONV ? (last ? DONE : CONV) :
              (out_ready ? IDLE : DONE);
  end
  // double-dabble step: add 3 to every digit >= 5, then shift the next binary MSB in
  always_comb begin
    adj = sh_q;
    for (int i = 0; i < DIGITS; i++)
      if (sh_q[4*i +: 4] >= 4'd5) adj[4*i +: 4] = sh_q[4*i +: 4] + 4'd3;
  end
  assign shl = {adj, bin_q} << 1;
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      a_q      <= '0;
      b_q      <= '0;
      cin_q    <= 1'b0;
      op_q     <= '0;
      result_q <= '0;
      neg_q    <= 1'b0;
      co_q     <= 1'b0;
      ov_q     <= 1'b0;
      sh_q     <= '0;
      bin_q    <= '0;
      bcd_q    <= '0;
      cnt_q    <= '0;
    end else begin
      state_q <= state_d;
      if (state_q == IDLE && in_valid) begin
        a_q   <= A;
        b_q   <= B;
        cin_q <= CarryIN;
        op_q  <= opCodeA;
      end
      if (state_q == EXEC) begin
        result_q <= res_d;
        neg_q    <= neg_d;
        co_q     <= co_d;
        ov_q     <= ov_d;
        sh_q     <= '0;
        bin_q    <= res_d;
        cnt_q    <= '0;
      end
      if (state_q == CONV) begin
        sh_q  <= shl[BW+RW-1 -: BW];
        bin_q <= shl[RW-1:0];
        cnt_q <= cnt_q + CW'(1);
        if (last) bcd_q <= shl[BW+RW-1 -: BW];
      end
    end
  end
  assign in_ready  = state_q == IDLE;
  assign out_valid = state_q == DONE;
  assign result    = result_q;
  assign bcd       = bcd_q;
  assign negative  = neg_q;
  assign CarryOUT  = co_q;
  assign overflow  = ov_q;
endmodule

// File: tb/tb_alu_bcd_seq.sv
// tb_alu_bcd_seq: directed-vector bench for alu_bcd_seq at WIDTH=8 and WIDTH=4
module tb_alu_bcd_seq;
  logic clk = 1'b0, rst = 1'b1;
  always #5 clk = ~clk;
  int checks = 0, errors = 0;
  logic iv, ir, cin, ova, ordy, neg, co, ovf;
  logic [7:0] a, b;
  logic [2:0] op;
  logic [15:0] res;
  logic [19:0] bcd;
  logic iv4, ir4, cin4, ova4, ordy4, neg4, co4, ovf4;
  logic [3:0] a4, b4;
  logic [2:0] op4;
  logic [7:0] res4;
  logic [11:0] bcd4;

  alu_bcd_seq #(.WIDTH(8), .DIGITS(5)) dut (
    .clk(clk), .rst(rst), .in_valid(iv), .in_ready(ir), .A(a), .B(b), .CarryIN(cin),
    .opCodeA(op), .out_valid(ova), .out_ready(ordy), .result(res), .bcd(bcd),
    .negative(neg), .CarryOUT(co), .overflow(ovf));

  alu_bcd_seq #(.WIDTH(4), .DIGITS(3)) dut4 (
    .clk(clk), .rst(rst), .in_valid(iv4), .in_ready(ir4), .A(a4), .B(b4), .CarryIN(cin4),
    .opCodeA(op4), .out_valid(ova4), .out_ready(ordy4), .result(res4), .bcd(bcd4),
    .negative(neg4), .CarryOUT(co4), .overflow(ovf4));

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic do_op(input logic [7:0] ta, input logic [7:0] tb, input logic tc, input logic [2:0] top,
                       input int hold, input logic [15:0] eres, input logic [19:0] ebcd,
                       input logic eneg, input logic eco, input logic eov);
    int n = 0;
    while (!ir && n < 100) begin @(posedge clk); #1; n++; end
    check("idle_before_op", ir, 1);
    a = ta; b = tb; cin = tc; op = top; iv = 1'b1;
    @(posedge clk); #1;
    iv = 1'b0; a = ~ta; b = ~tb; cin = ~tc; op = ~top;
    n = 1;
    while (!ova && n < 100) begin
      check("busy_in_ready", ir, 0);
      @(posedge clk); #1; n++;
    end
    check("latency", n, 18);
    check("result", res, eres);
    check("bcd", bcd, ebcd);
    check("negative", neg, eneg);
    check("carry", co, eco);
    check("overflow", ovf, eov);
    repeat (hold) begin
      @(posedge clk); #1;
      check("hold_valid", ova, 1);
      check("hold_in_ready", ir, 0);
      check("hold_bcd", bcd, ebcd);
      check("hold_result", res, eres);
    end
    ordy = 1'b1;
    @(posedge clk); #1;
    ordy = 1'b0;
    check("post_hs_valid", ova, 0);
    check("post_hs_in_ready", ir, 1);
  endtask

  initial begin
    int n;
    iv = 0; a = 0; b = 0; cin = 0; op = 0; ordy = 0;
    iv4 = 0; a4 = 0; b4 = 0; cin4 = 0; op4 = 0; ordy4 = 0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_in_ready", ir, 1);
    check("rst_out_valid", ova, 0);
    check("rst_result", res, 0);
    check("rst_bcd", bcd, 0);
    check("rst_flags", {neg, co, ovf}, 0);
    rst = 0;
    do_op(8'd100, 8'd100, 1'b0, 3'd0, 0, 16'd200, 20'h00200, 0, 0, 1);
    do_op(8'd200, 8'd100, 1'b1, 3'd0, 0, 16'd301, 20'h00301, 0, 1, 0);
    do_op(8'd5,   8'd9,   1'b0, 3'd1, 0, 16'd4,   20'h00004, 1, 1, 0);
    do_op(8'd9,   8'd5,   1'b1, 3'd1, 0, 16'd3,   20'h00003, 0, 0, 0);
    do_op(8'h80,  8'd1,   1'b0, 3'd1, 0, 16'd127, 20'h00127, 0, 0, 1);
    do_op(8'd255, 8'd255, 1'b0, 3'd2, 5, 16'd65025, 20'h65025, 0, 0, 0);
    do_op(8'hF0,  8'h3C,  1'b1, 3'd3, 0, 16'd48,  20'h00048, 0, 0, 0);
    do_op(8'hF0,  8'h0F,  1'b0, 3'd4, 0, 16'd255, 20'h00255, 0, 0, 0);
    do_op(8'hAA,  8'h55,  1'b0, 3'd5, 0, 16'd255, 20'h00255, 0, 0, 0);
    do_op(8'h0F,  8'h00,  1'b1, 3'd6, 0, 16'd240, 20'h00240, 0, 0, 0);
    do_op(8'd77,  8'd3,   1'b1, 3'd7, 0, 16'd77,  20'h00077, 0, 0, 0);
    do_op(8'd100, 8'd100, 1'b0, 3'd0, 0, 16'd200, 20'h00200, 0, 0, 1);
    a = 8'd255; b = 8'd255; cin = 0; op = 3'd2; iv = 1;
    @(posedge clk); #1;
    iv = 0;
    repeat (6) @(posedge clk);
    #1;
    check("mid_conv_busy", ir, 0);
    rst = 1; iv = 1;
    @(posedge clk); #1;
    check("rst_conv_in_ready", ir, 1);
    check("rst_conv_out_valid", ova, 0);
    check("rst_conv_result", res, 0);
    check("rst_conv_bcd", bcd, 0);
    check("rst_conv_flags", {neg, co, ovf}, 0);
    rst = 0; iv = 0;
    @(posedge clk); #1;
    check("no_accept_in_rst", ir, 1);
    do_op(8'd1, 8'd1, 1'b0, 3'd0, 0, 16'd2, 20'h00002, 0, 0, 0);
    a4 = 4'd12; b4 = 4'd12; op4 = 3'd2; iv4 = 1;
    @(posedge clk); #1;
    iv4 = 0;
    n = 1;
    while (!ova4 && n < 100) begin @(posedge clk); #1; n++; end
    check("w4_latency", n, 10);
    check("w4_result", res4, 8'd144);
    check("w4_bcd", bcd4, 12'h144);
    check("w4_carry", co4, 0);
    check("w4_overflow", ovf4, 0);
    ordy4 = 1;
    @(posedge clk); #1;
    ordy4 = 0;
    check("w4_post_hs", {ova4, ir4}, 2'b01);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
